// File: rtl/mult_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier.
//   state_t     : controller states (IDLE, RUN, DONE)
//   booth_sel_t : partial-product select produced by the Booth group encoder
//   booth_iters : number of radix-4 iterations for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        PLUS1  = 3'd1,
        PLUS2  = 3'd2,
        MINUS1 = 3'd3,
        MINUS2 = 3'd4
    } booth_sel_t;

    // Operands are extended by two bits, so the extended width is
    // WIDTH+2 and each iteration retires two multiplier bits.
    function automatic int booth_iters(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_enc4.sv
// Radix-4 Booth group encoder (purely combinational).
//   group : {b[2i+1], b[2i], b[2i-1]} of the multiplier
//   sel   : partial-product select (0, +A, +2A, -A, -2A)
module booth_enc4
    import mult_pkg::*;
(
    input  logic [2:0]  group,
    output booth_sel_t  sel
);

    always_comb begin
        sel = ZERO;
        case (group)
            3'b000: sel = ZERO;
            3'b001: sel = PLUS1;
            3'b010: sel = PLUS1;
            3'b011: sel = PLUS2;
            3'b100: sel = MINUS2;
            3'b101: sel = MINUS1;
            3'b110: sel = MINUS1;
            3'b111: sel = ZERO;
            default: sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one Booth group per clock.
//   clock        : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   start        : request a multiply (sampled in IDLE or DONE)
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned
//   multiplicand : operand A
//   multiplier   : operand B
//   busy         : high while iterating
//   done         : one-cycle pulse when result/overflow are valid
//   result       : full 2*WIDTH product, held until the next DONE
//   overflow     : product not representable in WIDTH bits
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 overflow
);

    localparam int EXT_W = WIDTH + 2;
    localparam int N     = booth_iters(WIDTH);
    localparam int CNT_W = $clog2(N + 1);

    state_t                    state, state_nxt;
    logic signed [EXT_W-1:0]   mcand_r;
    logic signed [EXT_W-1:0]   acc_r;
    logic        [EXT_W-1:0]   mplr_r;
    logic                      q_m1_r;
    logic                      mode_r;
    logic        [CNT_W-1:0]   cnt_r;

    booth_sel_t                sel;
    logic signed [EXT_W-1:0]   pp;
    logic signed [EXT_W-1:0]   sum;
    logic signed [EXT_W-1:0]   acc_nxt;
    logic        [EXT_W-1:0]   mplr_nxt;
    logic        [2*WIDTH-1:0] res_nxt;
    logic                      last_iter;
    logic                      load;

    // Unsigned operands get two zero bits so they are positive in the
    // signed WIDTH+2 datapath; signed operands are sign-extended.
    function automatic logic [EXT_W-1:0] extend(input logic [WIDTH-1:0] v,
                                                input logic sgn);
        return sgn ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
    endfunction

    // hi = result[2W-1:W-1]. Signed: upper W+1 bits must all match the
    // sign. Unsigned: upper W bits must be zero.
    function automatic logic calc_ovf(input logic [WIDTH:0] hi,
                                      input logic sgn);
        if (sgn)
            return !((&hi) || (~|hi));
        else
            return |hi[WIDTH:1];
    endfunction

    booth_enc4 u_enc (
        .group ({mplr_r[1:0], q_m1_r}),
        .sel   (sel)
    );

    // Magnitude of A is at most 2^WIDTH, so +-2A always fits in WIDTH+2
    // signed bits, and the running sum stays below 2^(WIDTH+1).
    always_comb begin
        pp = '0;
        case (sel)
            ZERO:    pp = '0;
            PLUS1:   pp = mcand_r;
            PLUS2:   pp = mcand_r <<< 1;
            MINUS1:  pp = -mcand_r;
            MINUS2:  pp = -(mcand_r <<< 1);
            default: pp = '0;
        endcase
    end

    assign sum       = acc_r + pp;
    assign acc_nxt   = sum >>> 2;
    assign mplr_nxt  = {sum[1:0], mplr_r[EXT_W-1:2]};
    // After the final shift {acc, mplr} holds the product; only the low
    // 2*WIDTH bits are meaningful.
    assign res_nxt   = {acc_nxt[WIDTH-3:0], mplr_nxt};
    assign last_iter = (cnt_r == CNT_W'(N - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter)
                    state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_r  <= '0;
            acc_r    <= '0;
            mplr_r   <= '0;
            q_m1_r   <= 1'b0;
            mode_r   <= 1'b0;
            cnt_r    <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            mcand_r  <= extend(multiplicand, signed_mode);
            mplr_r   <= extend(multiplier, signed_mode);
            mode_r   <= signed_mode;
            acc_r    <= '0;
            q_m1_r   <= 1'b0;
            cnt_r    <= '0;
        end else if (state == RUN) begin
            acc_r    <= acc_nxt;
            mplr_r   <= mplr_nxt;
            q_m1_r   <= mplr_r[1];
            cnt_r    <= cnt_r + CNT_W'(1);
            if (last_iter) begin
                result   <= res_nxt;
                overflow <= calc_ovf(res_nxt[2*WIDTH-1:WIDTH-1], mode_r);
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    localparam int W = 32;
    localparam int N = W / 2 + 1;

    logic            clock;
    logic            reset_n;
    logic            start;
    logic            signed_mode;
    logic [W-1:0]    multiplicand;
    logic [W-1:0]    multiplier;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  result;
    logic            overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact product by plain 64-bit arithmetic, overflow by range.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [63:0] p,
                                  output logic ov);
        longint    sp;
        logic [63:0] up;
        if (s) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
            ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end else begin
            up = {32'd0, a} * {32'd0, b};
            p  = up;
            ov = (up > 64'd4294967295);
        end
    endfunction

    // Called just before a rising edge; that edge samples start. Inputs
    // are scrambled right after it.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        start        = 1'b1;
        signed_mode  = s;
        multiplicand = a;
        multiplier   = b;
        @(posedge clock);
        #1;
        start        = 1'b0;
        signed_mode  = 1'($urandom_range(0, 1));
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Count falling edges after the sampling edge until done is seen.
    task automatic finish_op(input string tag, input int cyc0,
                             input logic [63:0] exp_p, input logic exp_o);
        int cyc;
        bit seen;
        cyc  = cyc0;
        seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(negedge clock);
            cyc++;
            if (done) seen = 1'b1;
        end
        chk_int({tag, " latency"}, cyc, N + 1);
        if (seen) begin
            chk1 ({tag, " busy_in_done"}, busy, 1'b0);
            chk64({tag, " result"}, result, exp_p);
            chk1 ({tag, " overflow"}, overflow, exp_o);
        end
    endtask

    task automatic run_op_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input logic [63:0] exp_p, input logic exp_o);
        @(negedge clock);
        drive_start(a, b, s);
        chk1({tag, " busy_after_start"}, busy, 1'b1);
        finish_op(tag, 0, exp_p, exp_o);
        @(negedge clock);
        chk1 ({tag, " done_single_cycle"}, done, 1'b0);
        chk64({tag, " result_held"}, result, exp_p);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        logic [63:0] ep;
        logic        eo;
        model(a, b, s, ep, eo);
        run_op_exp(tag, a, b, s, ep, eo);
    endtask

    initial begin
        int nd;
        logic [31:0] ra, rb;
        logic        rs;

        reset_n      = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clock);
        chk1 ("reset busy", busy, 1'b0);
        chk1 ("reset done", done, 1'b0);
        chk64("reset result", result, 64'd0);
        chk1 ("reset overflow", overflow, 1'b0);

        // Start on the very first rising edge after reset release.
        reset_n = 1'b1;
        drive_start(32'd7, 32'hFFFF_FFFD, 1'b1);
        chk1("s7xm3 busy_after_start", busy, 1'b1);
        finish_op("s7xm3", 0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        @(negedge clock);
        chk1("s7xm3 done_single_cycle", done, 1'b0);

        run_op_exp("u_ffff_x2", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE, 1'b1);
        run_op_exp("s_ffff_x2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op_exp("s_min_xm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 1'b1);
        run_op("zero_mcand", 32'd0, 32'hDEAD_BEEF, 1'b1);
        run_op("zero_mplr", 32'h1234_5678, 32'd0, 1'b0);
        run_op("s_min_x_min", 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op("u_max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // start pulsed during RUN must be ignored.
        @(negedge clock);
        drive_start(32'd5, 32'd6, 1'b1);
        repeat (3) @(negedge clock);
        start        = 1'b1;
        signed_mode  = 1'b0;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        @(negedge clock);
        start = 1'b0;
        finish_op("ignore_start", 4, 64'd30, 1'b0);
        nd = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) nd++;
        end
        chk_int("ignore_start extra_done", nd, 0);

        // Back-to-back: start raised in the DONE cycle.
        @(negedge clock);
        drive_start(32'd5, 32'd6, 1'b0);
        finish_op("b2b_first", 0, 64'd30, 1'b0);
        drive_start(32'd3, 32'd4, 1'b0);
        chk1("b2b busy_after_restart", busy, 1'b1);
        finish_op("b2b_second", 0, 64'd12, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clock);
        drive_start(32'd123456, 32'd789, 1'b0);
        repeat (8) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk1 ("midrun_reset busy", busy, 1'b0);
        chk1 ("midrun_reset done", done, 1'b0);
        chk64("midrun_reset result", result, 64'd0);
        chk1 ("midrun_reset overflow", overflow, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) nd++;
        end
        chk_int("midrun_reset no_done", nd, 0);
        run_op("after_reset", 32'hFFFF_FFF0, 32'd1000, 1'b1);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 3 == 0) begin
                ra = $urandom_range(0, 65535);
                rb = $urandom_range(0, 32767);
            end
            run_op($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
